// File: rtl/clk_en_pkg.sv
// Shared constants for the clock-enable generator: default counter width,
// the standard divisors for the serial, PWM and PID sample enables, and the
// channel index assigned to each consumer.
package clk_en_pkg;

    localparam int CNT_W_DEF  = 16;

    // Divisor value d gives one tick every d+1 clk_in cycles.
    localparam int SERIAL_DIV = 651;
    localparam int PWM_DIV    = 4000;
    localparam int PID_DIV    = 0;

    localparam int CH_SERIAL  = 0;
    localparam int CH_PWM     = 1;
    localparam int CH_PID     = 2;

endpackage : clk_en_pkg

// File: rtl/clk_en_channel.sv
// One clock-enable channel: a free-running counter compared against the active
// divisor, a shadow divisor that is only applied at a wrap (or at sync, or
// immediately while the channel is stopped), and a registered tick output.
// Optional macro CLKEN_PHASE_EN: the counter starts from PHASE (clamped to the
// active divisor) instead of 0 at reset, sync and while disabled.
module clk_en_channel
    import clk_en_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_INIT = '0,
    parameter logic [CNT_W-1:0] PHASE    = '0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shd;
    logic [CNT_W-1:0] start_sync;
    logic [CNT_W-1:0] start_hold;

`ifdef CLKEN_PHASE_EN
    // A phase beyond the period would never be reached; pin it to the terminal count.
    function automatic logic [CNT_W-1:0] clamp_start(input logic [CNT_W-1:0] ph,
                                                     input logic [CNT_W-1:0] lim);
        return (ph > lim) ? lim : ph;
    endfunction

    localparam logic [CNT_W-1:0] RST_START = (PHASE > DIV_INIT) ? DIV_INIT : PHASE;

    logic [CNT_W-1:0] sync_div;

    // At sync the divisor in force afterwards is the written value, else the shadow.
    assign sync_div   = wr ? wr_data : div_shd;
    assign start_sync = clamp_start(PHASE, sync_div);
    assign start_hold = clamp_start(PHASE, div_act);
`else
    localparam logic [CNT_W-1:0] RST_START = '0;

    logic unused_phase;

    assign unused_phase = ^PHASE;
    assign start_sync   = '0;
    assign start_hold   = '0;
`endif

    // Counter, divisor shadowing and tick register; sync outranks enable and wrap.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt     <= RST_START;
            div_act <= DIV_INIT;
            div_shd <= DIV_INIT;
            tick    <= 1'b0;
            pending <= 1'b0;
        end else if (sync) begin
            cnt     <= start_sync;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (wr) begin
                div_act <= wr_data;
                div_shd <= wr_data;
            end else begin
                div_act <= div_shd;
            end
        end else if (!en) begin
            cnt  <= start_hold;
            tick <= 1'b0;
            if (wr) begin
                div_act <= wr_data;
                div_shd <= wr_data;
                pending <= 1'b0;
            end
        end else if (cnt == div_act) begin
            cnt     <= '0;
            tick    <= 1'b1;
            pending <= 1'b0;
            if (wr) begin
                div_act <= wr_data;
                div_shd <= wr_data;
            end else begin
                div_act <= div_shd;
            end
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
            if (wr) begin
                div_shd <= wr_data;
                pending <= 1'b1;
            end
        end
    end

endmodule : clk_en_channel

// File: rtl/clock_enable_gen.sv
// N-channel clock-enable generator. Each channel ticks for one clk_in cycle
// every div+1 cycles; divisors are written through a shadow register so a
// running period is never cut short. sync restarts every channel together.
// Optional macro CLKEN_PHASE_EN: per-channel start offsets taken from PHASE.
module clock_enable_gen
    import clk_en_pkg::*;
#(
    parameter int                    N_CH     = 3,
    parameter int                    CNT_W    = CNT_W_DEF,
    parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {16'(PID_DIV), 16'(PWM_DIV), 16'(SERIAL_DIV)},
    parameter logic [N_CH*CNT_W-1:0] PHASE    = '0,
    localparam int                   SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             sync,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_wr_sel,
    input  logic [CNT_W-1:0] div_wr_data,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  div_pending
);

    logic [N_CH-1:0] wr_hit;

    // One-hot write decode; an index past the last channel selects nothing.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (div_wr && (div_wr_sel == SEL_W'(i))) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_en_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT[g*CNT_W +: CNT_W]),
            .PHASE    (PHASE[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk_in  (clk_in),
            .rst     (rst),
            .en      (ch_en[g]),
            .sync    (sync),
            .wr      (wr_hit[g]),
            .wr_data (div_wr_data),
            .tick    (tick[g]),
            .pending (div_pending[g])
        );
    end

endmodule : clock_enable_gen

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen with default parameters
// (ch0 div 651, ch1 div 4000, ch2 div 0). With CLKEN_PHASE_EN defined a second
// instance with a ch1 start offset of 2000 is also exercised.
module tb_clock_enable_gen;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic [2:0]  ch_en  = 3'b000;
    logic        sync   = 1'b0;
    logic        div_wr = 1'b0;
    logic [1:0]  div_wr_sel  = 2'd0;
    logic [15:0] div_wr_data = 16'd0;
    logic [2:0]  tick;
    logic [2:0]  div_pending;

    int checks = 0;
    int errors = 0;
    int n;
    int hits;

    always #5 clk_in = ~clk_in;

    clock_enable_gen dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .ch_en       (ch_en),
        .sync        (sync),
        .div_wr      (div_wr),
        .div_wr_sel  (div_wr_sel),
        .div_wr_data (div_wr_data),
        .tick        (tick),
        .div_pending (div_pending)
    );

`ifdef CLKEN_PHASE_EN
    logic [2:0] tick_ph;
    logic [2:0] pend_ph;

    clock_enable_gen #(
        .PHASE ({16'd0, 16'd2000, 16'd0})
    ) dut_ph (
        .clk_in      (clk_in),
        .rst         (rst),
        .ch_en       (ch_en),
        .sync        (1'b0),
        .div_wr      (1'b0),
        .div_wr_sel  (2'd0),
        .div_wr_data (16'd0),
        .tick        (tick_ph),
        .div_pending (pend_ph)
    );

    task automatic wait_tick_ph(input int ch, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk_in); #1;
            cnt++;
        end while (!tick_ph[ch] && cnt < limit);
        if (!tick_ph[ch]) cnt = -1;
    endtask
`endif

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk_in); #1;
        end
    endtask

    // Edges until tick[ch] is seen high; -1 if the budget runs out.
    task automatic wait_tick(input int ch, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk_in); #1;
            cnt++;
        end while (!tick[ch] && cnt < limit);
        if (!tick[ch]) cnt = -1;
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_tick", tick, 3'b000);
        chk("rst_pending", div_pending, 3'b000);
        rst   = 1'b0;
        ch_en = 3'b111;

        // Default periods
        wait_tick(0, 5000, n);
        chk("ch0_first", n, 652);
        chk("tick_at_652", tick, 3'b101);
        wait_tick(0, 5000, n);
        chk("ch0_period", n, 652);
        wait_tick(1, 5000, n);
        chk("ch1_first", n, 2697);
        chk("tick_at_4001", tick, 3'b110);

        // Mid-period write to ch1
        div_wr = 1'b1; div_wr_sel = 2'd1; div_wr_data = 16'd9;
        step(1);
        div_wr = 1'b0;
        chk("ch1_pending_set", div_pending, 3'b010);
        wait_tick(1, 5000, n);
        chk("ch1_old_period_completes", n, 4000);
        chk("ch1_pending_clear", div_pending, 3'b000);
        wait_tick(1, 5000, n);
        chk("ch1_new_period_a", n, 10);
        wait_tick(1, 5000, n);
        chk("ch1_new_period_b", n, 10);

        // Write on the terminal-count cycle of ch0
        wait_tick(0, 5000, n);
        step(651);
        chk("ch0_before_wrap", tick[0], 1'b0);
        div_wr = 1'b1; div_wr_sel = 2'd0; div_wr_data = 16'd3;
        step(1);
        div_wr = 1'b0;
        chk("ch0_wrap_tick", tick[0], 1'b1);
        chk("ch0_tc_write_no_pending", div_pending, 3'b000);
        wait_tick(0, 5000, n);
        chk("ch0_tc_period_a", n, 4);
        wait_tick(0, 5000, n);
        chk("ch0_tc_period_b", n, 4);

        // sync together with a write to ch0
        step(2);
        sync = 1'b1; div_wr = 1'b1; div_wr_sel = 2'd0; div_wr_data = 16'd651;
        step(1);
        sync = 1'b0; div_wr = 1'b0;
        chk("sync_tick_low", tick, 3'b000);
        chk("sync_pending", div_pending, 3'b000);
        wait_tick(2, 5000, n);
        chk("sync_ch2", n, 1);
        wait_tick(1, 5000, n);
        chk("sync_ch1", n, 9);
        wait_tick(0, 5000, n);
        chk("sync_ch0_write_applied", n, 642);

        // sync applies a pending shadow
        div_wr = 1'b1; div_wr_sel = 2'd1; div_wr_data = 16'd4;
        step(1);
        div_wr = 1'b0;
        chk("pend_before_sync", div_pending, 3'b010);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("pend_after_sync", div_pending, 3'b000);
        wait_tick(1, 5000, n);
        chk("sync_applied_shadow", n, 5);

        // Disable ch0, write while disabled
        ch_en = 3'b110;
        div_wr = 1'b1; div_wr_sel = 2'd0; div_wr_data = 16'd7;
        step(1);
        div_wr = 1'b0;
        chk("dis_write_no_pending", div_pending[0], 1'b0);
        hits = int'(tick[0]);
        for (int i = 0; i < 99; i++) begin
            step(1);
            hits += int'(tick[0]);
        end
        chk("dis_no_tick", hits, 0);
        ch_en = 3'b111;
        wait_tick(0, 5000, n);
        chk("reenable_first", n, 8);

        // Out-of-range select is ignored
        div_wr = 1'b1; div_wr_sel = 2'd3; div_wr_data = 16'd0;
        step(1);
        div_wr = 1'b0;
        chk("sel3_pending", div_pending, 3'b000);
        wait_tick(0, 5000, n);
        chk("sel3_ch0_rest", n, 7);
        wait_tick(0, 5000, n);
        chk("sel3_ch0_period", n, 8);
        wait_tick(1, 5000, n);
        wait_tick(1, 5000, n);
        chk("sel3_ch1_period", n, 5);

        // Reset mid-count
        div_wr = 1'b1; div_wr_sel = 2'd1; div_wr_data = 16'd2;
        step(1);
        div_wr = 1'b0;
        chk("pre_rst_pending", div_pending, 3'b010);
        chk("pre_rst_tick2", tick[2], 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_tick", tick, 3'b000);
        chk("async_rst_pending", div_pending, 3'b000);
        step(2);
        rst = 1'b0;
        wait_tick(0, 5000, n);
        chk("post_rst_ch0", n, 652);
        wait_tick(1, 5000, n);
        chk("post_rst_ch1", n, 3349);

`ifdef CLKEN_PHASE_EN
        // Offset instance: ch1 started at 2000, first tick at 2001, next at 6002
        wait_tick_ph(1, 5000, n);
        chk("phase_ch1_second", n, 2001);
        wait_tick_ph(1, 5000, n);
        chk("phase_ch1_period", n, 4001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clock_enable_gen
